// File: rtl/fft_pkg.sv
// Shared FFT constants and helpers, used by the FFT top level, reorder stage
// and the spectrum consumers.
package fft_pkg;
  localparam int FFT_POINTS = 64;
  localparam int FFT_BEATS  = 32;
  localparam int NUM_BANDS  = 4;
  localparam int BAND_BINS  = 8;
  localparam int LOG_BEATS  = 5;

  typedef logic [LOG_BEATS-1:0] bin_t;

  // Bins are grouped in runs of BAND_BINS, so the band is the top bin bits.
  function automatic logic [1:0] band_of(input bin_t bin);
    return bin[LOG_BEATS-1 -: 2];
  endfunction
endpackage

// File: rtl/fft_cpower.sv
// Two-stage complex power: registered squares, then registered sum.
// A valid bit and a bin tag travel alongside the data.
module fft_cpower
  import fft_pkg::*;
#(
  parameter int width = 11,
  parameter int pw    = 2*width
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ce,
  input  logic                    valid_i,
  input  bin_t                    tag_i,
  input  logic signed [width-1:0] xr,
  input  logic signed [width-1:0] xi,
  output logic                    valid_o,
  output bin_t                    tag_o,
  output logic [pw-1:0]           pow
);
  localparam int STAGES = 2;

  logic [STAGES:1]       vld_pipe;
  bin_t [STAGES:1]       tag_pipe;
  logic signed [pw-1:0]  xr_e, xi_e;
  logic [pw-1:0]         sq_r, sq_i;

  // Sign-extend first so the product is formed at full width.
  assign xr_e = pw'(xr);
  assign xi_e = pw'(xi);

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      sq_r     <= '0;
      sq_i     <= '0;
      pow      <= '0;
    end else if (ce) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], valid_i};
      tag_pipe <= {tag_pipe[STAGES-1:1], tag_i};
      sq_r     <= xr_e * xr_e;
      sq_i     <= xi_e * xi_e;
      pow      <= sq_r + sq_i;
    end
  end

  assign valid_o = vld_pipe[STAGES];
  assign tag_o   = tag_pipe[STAGES];
endmodule

// File: rtl/fft64_spectrum_peak.sv
// Per-frame spectrum summary of the 64-point FFT: strongest non-DC bin among
// bins 1..31 plus four 8-bin band energies, reported once per frame.
module fft64_spectrum_peak
  import fft_pkg::*;
#(
  parameter int width = 11,
  parameter int pw    = 2*width,
  parameter int bw    = 2*width+3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ce,
  input  logic                    valid_i,
  input  logic signed [width-1:0] xr,
  input  logic signed [width-1:0] xi,
  input  logic signed [width-1:0] yr,
  input  logic signed [width-1:0] yi,
  output logic                    valid_o,
  output logic [4:0]              peak_bin,
  output logic [pw-1:0]           peak_pow,
  output logic [4*bw-1:0]         band_e
);
  bin_t                         beat_cnt;
  logic                         p_vld;
  bin_t                         p_tag;
  logic [pw-1:0]                p_pow;
  bin_t                         pk_bin_q, pk_bin_d;
  logic [pw-1:0]                pk_pow_q, pk_pow_d;
  logic [NUM_BANDS-1:0][bw-1:0] acc_q, acc_d, band_q;
  logic                         frame_end;
  logic                         unused_y;

  // Upper half of the spectrum mirrors the lower half for real input.
  assign unused_y = ^{yr, yi};

  always_ff @(posedge CLK) begin
    if (RST)                beat_cnt <= '0;
    else if (ce && valid_i) beat_cnt <= beat_cnt + 1'b1;
  end

  fft_cpower #(.width(width), .pw(pw)) u_cpower (
    .CLK     (CLK),
    .RST     (RST),
    .ce      (ce),
    .valid_i (valid_i),
    .tag_i   (beat_cnt),
    .xr      (xr),
    .xi      (xi),
    .valid_o (p_vld),
    .tag_o   (p_tag),
    .pow     (p_pow)
  );

  // Bin 1 seeds the tracker; strict compare keeps the lowest bin on ties.
  always_comb begin
    pk_bin_d = pk_bin_q;
    pk_pow_d = pk_pow_q;
    acc_d    = acc_q;
    acc_d[band_of(p_tag)] = acc_q[band_of(p_tag)] + bw'(p_pow);
    if (p_tag == bin_t'(1) || (p_tag != '0 && p_pow > pk_pow_q)) begin
      pk_bin_d = p_tag;
      pk_pow_d = p_pow;
    end
  end

  assign frame_end = p_vld && (p_tag == bin_t'(FFT_BEATS-1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_o  <= 1'b0;
      peak_bin <= '0;
      peak_pow <= '0;
      band_q   <= '0;
      acc_q    <= '0;
      pk_bin_q <= '0;
      pk_pow_q <= '0;
    end else if (ce) begin
      valid_o <= frame_end;
      if (frame_end) begin
        peak_bin <= pk_bin_d;
        peak_pow <= pk_pow_d;
        band_q   <= acc_d;
        acc_q    <= '0;
        pk_bin_q <= '0;
        pk_pow_q <= '0;
      end else if (p_vld) begin
        acc_q    <= acc_d;
        pk_bin_q <= pk_bin_d;
        pk_pow_q <= pk_pow_d;
      end
    end
  end

  assign band_e = band_q;
endmodule

// File: doc/fft64_spectrum_peak.md
# fft64_spectrum_peak

Downstream consumer of the 64-point FFT top level. It takes the reordered two-samples-per-beat FFT output stream and computes the power of each positive-frequency bin. Once per 64-point frame it reports the strongest non-DC bin, its power, and four band energies. Game logic uses these results as its audio-reactive control input.

## Interface
Parameters:
- `width`, 11, signed component width of the FFT output (matches the FFT top level).
- `pw`, `2*width`, unsigned per-bin power width.
- `bw`, `2*width+3`, unsigned band-energy width.

Ports:
- `CLK`  in  1  single clock.
- `RST`  in  1  synchronous, active-high reset.
- `ce`  in  1  clock enable; all state, counters and pipeline stages advance only when `ce`=1.
- `valid_i`  in  1  beat valid from the FFT reorder output.
- `xr`, `xi`  in  `width`  signed; bin n on beat n (n = 0..31).
- `yr`, `yi`  in  `width`  signed; bin n+32 on beat n; ignored by this block.
- `valid_o`  out  1  frame-result strobe.
- `peak_bin`  out  5  index of the strongest bin (1..31).
- `peak_pow`  out  `pw`  power of `peak_bin`.
- `band_e`  out  `4*bw`  band energies; band k occupies bits [k*bw +: bw].

## Operation
- Beat accept: `ce`=1 and `valid_i`=1. A 5-bit beat counter starts at 0, increments per accepted beat, and wraps 31→0. The beat index is the bin index.
- Power: p = xr² + xi², computed exactly and unsigned. Max input is (−2^(width−1))²·2 = 2^(2·width−1), which fits in `pw`.
- Pipeline: stage 1 registers both squares and the bin index. Stage 2 registers the sum p and the bin index. Stage 3 performs accumulate/compare.
- Peak tracking:
  - Bin 0 (DC) is excluded from the peak search.
  - Bin 1 loads the tracker unconditionally.
  - Bins 2..31 replace the tracker only when p > current peak (strictly greater), so on ties the lowest bin wins.
- Bands: band k = sum of p over bins 8k..8k+7. Bin 0 is included in band 0. The sum of 8 bins fits in `bw`, so no saturation is needed.
- Frame end: when stage 3 processes bin 31, the final peak and band values are copied to the output registers and `valid_o` is set. The accumulators clear for the next frame in the same cycle, so back-to-back frames need no idle beat.
- Gaps: beats may arrive non-contiguously. Results depend only on accepted beats.
- `RST` clears the beat counter, pipeline valids, accumulators, tracker, `valid_o`=0, `peak_bin`=0, `peak_pow`=0 and `band_e`=0. A partially received frame is discarded. The first beat accepted after reset is bin 0.

## Timing
- Latency: `valid_o` rises 3 ce-cycles after the ce-cycle that accepts bin 31.
- `valid_o` is high for exactly one ce=1 cycle. If `ce` drops while it is high, it holds and then clears on the next ce=1 cycle.
- `peak_bin`, `peak_pow` and `band_e` hold their values until the next frame end.
- `ce`=0 freezes everything, including partially filled pipeline stages. `valid_i` is don't-care while `ce`=0.
- No backpressure: the block accepts one beat per ce-cycle indefinitely.

## Structure
- Shared package `fft_pkg`: constants `FFT_POINTS`=64, `FFT_BEATS`=32, `NUM_BANDS`=4, `BAND_BINS`=8, `LOG_BEATS`=5. The FFT top level and reorder stage also use this package.
- Sub-module `fft_cpower`: a 2-stage pipelined complex-power unit (squares, then sum). It carries a valid bit and a tag (the bin index) alongside the data, and uses the same `ce`.
- The top level contains the beat counter, tracker, band accumulators and output registers.

## Test plan
- Single tone: bin 5 = (300, −400), all other bins 0. Expect `peak_bin`=5, `peak_pow`=250000, band0=250000, bands 1–3 = 0, and `valid_o` 3 cycles after beat 31.
- DC dominance and tie: bin 0 = (1000, 0); bins 9 and 20 = (100, 100); all others 0. Expect `peak_bin`=9, `peak_pow`=20000, band0=1000000, band1=20000, band2=20000, band3=0.
- Extremes: every bin = (−1024, −1024). Expect p=2097152 per bin, each band = 16777216, `peak_bin`=1.
- Back-to-back frames with `ce` toggling randomly: frame A has its peak at bin 31, frame B at bin 2. Expect exactly two `valid_o` pulses, each one ce-cycle long, with correct per-frame values and no cross-frame leakage.
- `RST` asserted after beat 17 of a frame, then a full new frame (tone at bin 12). Expect no `valid_o` for the aborted frame and `peak_bin`=12 for the new one. All outputs are 0 while reset is held.
